// File: rtl/path_tracer.sv
// Traces a path on a 2^N x 2^N grid from (0,0) by applying move codes read from a result list.
// Optional macro TRACE_BOUNDS_CHECK_EN turns off-grid moves into a fault instead of wrapping.
module path_tracer #(
  parameter int N              = 4,
  parameter int DIRECTION_SIZE = 2,
  parameter int STEP_W         = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      move_valid,
  input  logic [DIRECTION_SIZE-1:0] Move,
  input  logic                      complete_read,
  output logic                      en_read,
  output logic [N-1:0]              PX,
  output logic [N-1:0]              PY,
  output logic                      pos_valid,
  output logic [STEP_W-1:0]         step_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    UPDATE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [N-1:0]              px_q, px_d;
  logic [N-1:0]              py_q, py_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [DIRECTION_SIZE-1:0] move_q, move_d;
  logic                      pos_valid_q, pos_valid_d;
  logic                      en_read_q, en_read_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [N-1:0]              px_nxt, py_nxt;
`ifdef TRACE_BOUNDS_CHECK_EN
  logic                      off_grid;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    step_d      = step_q;
    move_d      = move_q;
    pos_valid_d = 1'b0;
    px_nxt      = px_q;
    py_nxt      = py_q;
`ifdef TRACE_BOUNDS_CHECK_EN
    off_grid    = 1'b0;
`endif

    unique case (move_q[1:0])
      2'b00: px_nxt = px_q + N'(1);
      2'b01: py_nxt = py_q + N'(1);
      2'b10: px_nxt = px_q - N'(1);
      2'b11: py_nxt = py_q - N'(1);
    endcase

`ifdef TRACE_BOUNDS_CHECK_EN
    unique case (move_q[1:0])
      2'b00: off_grid = &px_q;
      2'b01: off_grid = &py_q;
      2'b10: off_grid = ~|px_q;
      2'b11: off_grid = ~|py_q;
    endcase
`endif

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = FETCH;
          px_d    = '0;
          py_d    = '0;
          step_d  = '0;
        end
      end
      FETCH: begin
        // A valid move wins over complete_read; the flag is looked at again on the next FETCH.
        if (move_valid) begin
          move_d  = Move;
          state_d = UPDATE;
        end else if (complete_read) begin
          state_d = CHECK;
        end
      end
      UPDATE: begin
        state_d = FETCH;
`ifdef TRACE_BOUNDS_CHECK_EN
        if (off_grid) begin
          state_d = ERR;
        end else begin
          px_d        = px_nxt;
          py_d        = py_nxt;
          pos_valid_d = 1'b1;
          if (step_q != '1) step_d = step_q + STEP_W'(1);
        end
`else
        px_d        = px_nxt;
        py_d        = py_nxt;
        pos_valid_d = 1'b1;
        if (step_q != '1) step_d = step_q + STEP_W'(1);
`endif
      end
      CHECK: begin
        state_d = (&px_q && &py_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered, so they are decoded from the state being entered.
    en_read_d = (state_d == FETCH);
    busy_d    = (state_d == FETCH) || (state_d == UPDATE) || (state_d == CHECK);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      step_q      <= '0;
      move_q      <= '0;
      pos_valid_q <= 1'b0;
      en_read_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      step_q      <= step_d;
      move_q      <= move_d;
      pos_valid_q <= pos_valid_d;
      en_read_q   <= en_read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign en_read   = en_read_q;
  assign PX        = px_q;
  assign PY        = py_q;
  assign pos_valid = pos_valid_q;
  assign step_cnt  = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer (N=4, STEP_W=8); expectations are hand-computed.
// Build with TRACE_BOUNDS_CHECK_EN defined to exercise the bounded variant.
module tb_path_tracer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, move_valid, complete_read;
  logic [1:0] move;
  logic       en_read, pos_valid, busy, done, err;
  logic [3:0] px, py;
  logic [7:0] step_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_en, cnt_pv;

  path_tracer dut (
    .CLK          (clk),
    .RST          (rst_n),
    .start        (start),
    .move_valid   (move_valid),
    .Move         (move),
    .complete_read(complete_read),
    .en_read      (en_read),
    .PX           (px),
    .PY           (py),
    .pos_valid    (pos_valid),
    .step_cnt     (step_cnt),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fetch(input string tag);
    int k = 0;
    while (en_read !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (en_read !== 1'b1) check({tag, "_fetch_timeout"}, 32'(en_read), 1);
  endtask

  // Transfers one move; returns in the FETCH cycle that shows the updated position.
  task automatic send_move(input logic [1:0] code);
    wait_fetch("send_move");
    move_valid = 1'b1;
    move       = code;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_list();
    wait_fetch("finish_list");
    complete_read = 1'b1;
    @(negedge clk);
    complete_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; complete_read = 1'b0; move = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_px", 32'(px), 0);
    check("rst_py", 32'(py), 0);
    check("rst_step", 32'(step_cnt), 0);
    check("rst_en_read", 32'(en_read), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", 32'({done, err, pos_valid}), 0);

    do_start();
    check("start_en_read", 32'(en_read), 1);
    check("start_busy", 32'(busy), 1);

    // Idle list: en_read stays high, nothing moves
    cnt_en = 0; cnt_pv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt_en += int'(en_read);
      cnt_pv += int'(pos_valid);
    end
    check("stall_en_read_cycles", 32'(cnt_en), 5);
    check("stall_pos_valid_cycles", 32'(cnt_pv), 0);
    check("stall_px", 32'(px), 0);

    // start while busy is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_en_read", 32'(en_read), 1);
    check("busy_start_busy", 32'(busy), 1);

    // First move, watching the UPDATE cycle explicitly
    move_valid = 1'b1; move = 2'b00;
    @(negedge clk);
    move_valid = 1'b0;
    check("upd_en_read", 32'(en_read), 0);
    check("upd_px_not_yet", 32'(px), 0);
    @(negedge clk);
    check("upd_px", 32'(px), 1);
    check("upd_pos_valid", 32'(pos_valid), 1);
    check("upd_step", 32'(step_cnt), 1);
    @(negedge clk);
    check("pos_valid_one_cycle", 32'(pos_valid), 0);

    // Moves 00,01 then complete_read off goal -> ERR
    send_move(2'b01);
    finish_list();
    check("err_px_py", 32'({px, py}), 32'h11);
    check("err_flags", 32'({busy, done, err}), 32'b001);
    check("err_step", 32'(step_cnt), 2);
    @(negedge clk);
    check("err_hold", 32'({px, py, err}), 32'h023);

    do_start();
    check("restart_pos", 32'({px, py, step_cnt}), 0);
    check("restart_flags", 32'({busy, done, err}), 32'b100);

    // 15 right, 15 up, complete -> goal
    for (int i = 0; i < 15; i++) send_move(2'b00);
    for (int i = 0; i < 15; i++) send_move(2'b01);
    finish_list();
    check("goal_px_py", 32'({px, py}), 32'hFF);
    check("goal_step", 32'(step_cnt), 30);
    check("goal_flags", 32'({busy, done, err}), 32'b010);

    // Left from the origin
    do_start();
    send_move(2'b10);
`ifdef TRACE_BOUNDS_CHECK_EN
    check("bound_px", 32'(px), 0);
    check("bound_step", 32'(step_cnt), 0);
    check("bound_err", 32'({busy, err, pos_valid}), 32'b010);
`else
    check("wrap_px", 32'(px), 15);
    check("wrap_step", 32'(step_cnt), 1);
    check("wrap_err", 32'(err), 0);
`endif

    // Move and complete_read together: the move is applied first
    do_start();
    move_valid = 1'b1; move = 2'b01; complete_read = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    check("both_update_busy", 32'({busy, en_read}), 32'b10);
    @(negedge clk);
    check("both_py", 32'(py), 1);
    check("both_fetch_again", 32'(en_read), 1);
    @(negedge clk);
    complete_read = 1'b0;
    check("both_check_state", 32'({busy, en_read}), 32'b10);
    @(negedge clk);
    check("both_err", 32'({done, err}), 32'b01);

    // Asynchronous reset mid-trace
    do_start();
    for (int i = 0; i < 3; i++) send_move(2'b00);
    check("pre_reset_px", 32'(px), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pos", 32'({px, py}), 0);
    check("async_rst_en_read", 32'(en_read), 0);
    check("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'({en_read, busy}), 0);

    // Step counter saturation: 260 moves that cancel out
    do_start();
    for (int i = 0; i < 130; i++) begin
      send_move(2'b00);
      send_move(2'b10);
    end
    check("sat_step", 32'(step_cnt), 255);
    check("sat_px", 32'(px), 0);
    finish_list();
    check("sat_err", 32'({done, err}), 32'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
